bcd_seg7_scan: RTL and testbench
================================

// Module: bcd_seg7_scan
// PURPOSE
//  Display stage directly downstream of the BCD digit adder: captures adder result {CARRY,S}
//  on a LOAD strobe and drives a 2-digit multiplexed 7-segment display (units = S, tens = CARRY).
//  Contains a scan prescaler and digit-select state. Flags non-BCD sums (S > 9).
// PARAMETERS
//  DIV    4   scan prescaler: digit select toggles every DIV clocks (DIV >= 1; 4 for sim, large on board)
//  BLANK  1   1 = tens digit blanked when captured CARRY=0; 0 = tens shows "0"
// PORTS
//  CLK    in   1  single system clock, all state on rising edge
//  RST    in   1  synchronous reset, active-high
//  S      in   4  BCD sum digit from adder
//  CARRY  in   1  decimal carry from adder
//  LOAD   in   1  capture strobe; samples S/CARRY on the same edge
//  SEG    out  7  segments {g,f,e,d,c,b,a}, active-high, registered
//  AN     out  2  digit enables, active-low, registered; AN[0]=units, AN[1]=tens
//  ERR    out  1  captured S > 9, registered
// BEHAVIOUR
//  Clock/reset: one clock CLK; RST is synchronous, active-high; RST has priority over LOAD.
//  Reset (edge with RST=1): cnt=0, sel=0, dig=4'h0, cy=0, SEG=7'h00, AN=2'b11, ERR=0.
//  Capture: edge with LOAD=1 & RST=0 -> dig<=S, cy<=CARRY, ERR<=(S>4'd9). Otherwise held.
//  Prescaler: cnt counts 0..DIV-1; at cnt==DIV-1 -> cnt<=0, sel<=~sel; else cnt<=cnt+1.
//   DIV=1: sel toggles every clock. cnt width = clog2(DIV), min 1 bit.
//  State: sel is 2-state scan FSM: UNITS(0) <-> TENS(1), transition only on prescaler terminal count.
//  Output register (every edge with RST=0), computed from pre-edge sel/dig/cy:
//   sel=0: AN<=2'b10, SEG<=enc(dig); sel=1: AN<=2'b01, SEG<=tens code.
//   Latency: value captured at edge n appears on SEG at edge n+1 if its digit is selected.
//   First edge after reset release: AN=2'b10, SEG=enc(0)=7'h3F.
//  enc(): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; A..F -> 7'h40 (dash).
//  Tens code: cy=1 -> 7'h06; cy=0 -> 7'h00 if BLANK=1, else 7'h3F.
//  Exactly one AN bit low at any time after reset release; never both low.
//  LOAD while scanning: prescaler/sel unaffected; no glitch beyond the 1-cycle update.
//  LOAD held high: re-captures every edge (transparent tracking, 1-cycle lag).
//  Reset mid-scan: all state returns to reset values on that edge; scan restarts at UNITS.
// TESTING (DIV=4, BLANK=1 unless stated)
//  1 RST 2 clks, release -> AN=11 during reset; next edge AN=10 SEG=3F ERR=0; AN flips every 4 clks.
//  2 LOAD S=8 CY=0 (3+5) -> units phase SEG=7F; tens phase SEG=00; ERR=0.
//  3 LOAD S=0 CY=1 (4+6) -> units SEG=3F, tens SEG=06; 9+9: S=8 CY=1 -> 7F / 06.
//  4 LOAD S=4'hC CY=0 -> ERR=1, units SEG=40; then LOAD S=3 -> ERR=0, SEG=4F.
//  5 RST asserted with LOAD=1 mid tens phase -> next edge AN=11 SEG=00, dig=0; capture ignored.
//  6 DIV=1, BLANK=0, LOAD S=7 CY=0 -> AN alternates 10/01 each clk; SEG alternates 07/3F.

Source files
------------

// File: rtl/bcd_seg7_scan_if.sv
// ============================================================================
// Module   : bcd_seg7_scan_if
// Brief    : Adder-result capture inputs and multiplexed 7-segment outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_seg7_scan_if;
    logic [3:0] s;
    logic       carry;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (
        output s,
        output carry,
        output load,
        input  seg,
        input  an,
        input  err
    );

    modport slave (
        input  s,
        input  carry,
        input  load,
        output seg,
        output an,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/bcd_seg7_scan.sv
// ============================================================================
// Module   : bcd_seg7_scan
// Brief    : Captures a BCD adder result and scans it onto a 2-digit display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_seg7_scan #(
    parameter int DIV   = 4,
    parameter bit BLANK = 1'b1
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    bcd_seg7_scan_if.slave  bus
);

    localparam int              CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [0:0]       ST_UNITS   = 1'b0;
    localparam logic [0:0]       ST_TENS    = 1'b1;
    localparam logic [6:0]       C_SEG_ONE  = 7'h06;
    localparam logic [6:0]       C_SEG_ZERO = 7'h3F;
    localparam logic [6:0]       C_SEG_OFF  = 7'h00;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       sel_q, sel_d;
    logic [3:0]       dig_q;
    logic             cy_q;
    logic             err_q;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             tc;

    // Non-decimal codes show a dash so a bad sum is visible on the board.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h40;
        endcase
        return r;
    endfunction

    always_comb begin
        tc    = (cnt_q == C_CNT_LAST);
        cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sel_q <= ST_UNITS;
            dig_q <= 4'h0;
            cy_q  <= 1'b0;
            err_q <= 1'b0;
            seg_q <= C_SEG_OFF;
            an_q  <= 2'b11;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
            an_q  <= an_d;
            if (bus.load) begin
                dig_q <= bus.s;
                cy_q  <= bus.carry;
                err_q <= (bus.s > 4'd9);
            end
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (tc) begin
            case (sel_q)
                ST_UNITS: sel_d = ST_TENS;
                ST_TENS:  sel_d = ST_UNITS;
                default:  sel_d = ST_UNITS;
            endcase
        end
    end

    always_comb begin
        an_d  = 2'b11;
        seg_d = C_SEG_OFF;
        case (sel_q)
            ST_UNITS: begin
                an_d  = 2'b10;
                seg_d = enc(dig_q);
            end
            ST_TENS: begin
                an_d  = 2'b01;
                seg_d = cy_q ? C_SEG_ONE : (BLANK ? C_SEG_OFF : C_SEG_ZERO);
            end
            default: begin
                an_d  = 2'b11;
                seg_d = C_SEG_OFF;
            end
        endcase
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg7_scan.sv
// ============================================================================
// Module   : tb_bcd_seg7_scan
// Brief    : Scoreboard bench for bcd_seg7_scan (DIV=4/BLANK=1 and DIV=1/BLANK=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_seg7_scan;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_seg7_scan_if if0 ();
    bcd_seg7_scan_if if1 ();

    bcd_seg7_scan #(.DIV(4), .BLANK(1'b1)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if0.slave)
    );

    bcd_seg7_scan #(.DIV(1), .BLANK(1'b0)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'h3F; seg_tab[1]  = 7'h06; seg_tab[2]  = 7'h5B; seg_tab[3]  = 7'h4F;
        seg_tab[4]  = 7'h66; seg_tab[5]  = 7'h6D; seg_tab[6]  = 7'h7D; seg_tab[7]  = 7'h07;
        seg_tab[8]  = 7'h7F; seg_tab[9]  = 7'h6F;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'h40;
    end

    // Expected {an,seg} from the number of running edges since reset release.
    function automatic logic [8:0] exp_disp(int t, int div, bit blank,
                                             logic [3:0] dig, logic cy);
        logic [6:0] tens;
        tens = cy ? 7'h06 : (blank ? 7'h00 : 7'h3F);
        if (((t / div) % 2) == 0) return {2'b10, seg_tab[dig]};
        else                      return {2'b01, tens};
    endfunction

    logic [9:0] q0 [$];
    logic [9:0] q1 [$];

    int         t0 = 0, t1 = 0;
    logic [3:0] d0 = 4'h0, d1 = 4'h0;
    logic       c0 = 1'b0, c1 = 1'b0;
    logic       e0 = 1'b0, e1 = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q0.push_back({2'b11, 7'h00, 1'b0});
            t0 = 0; d0 = 4'h0; c0 = 1'b0; e0 = 1'b0;
        end else begin
            if (if0.load) e0 = (if0.s > 4'd9);
            q0.push_back({exp_disp(t0, 4, 1'b1, d0, c0), e0});
            if (if0.load) begin d0 = if0.s; c0 = if0.carry; end
            t0++;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            q1.push_back({2'b11, 7'h00, 1'b0});
            t1 = 0; d1 = 4'h0; c1 = 1'b0; e1 = 1'b0;
        end else begin
            if (if1.load) e1 = (if1.s > 4'd9);
            q1.push_back({exp_disp(t1, 1, 1'b0, d1, c1), e1});
            if (if1.load) begin d1 = if1.s; c1 = if1.carry; end
            t1++;
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("d4_an",  {30'd0, if0.an},  {30'd0, e[9:8]});
            check("d4_seg", {25'd0, if0.seg}, {25'd0, e[7:1]});
            check("d4_err", {31'd0, if0.err}, {31'd0, e[0]});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("d1_an",  {30'd0, if1.an},  {30'd0, e[9:8]});
            check("d1_seg", {25'd0, if1.seg}, {25'd0, e[7:1]});
            check("d1_err", {31'd0, if1.err}, {31'd0, e[0]});
        end
    end

    task automatic load0(input logic [3:0] s, input logic cy, input int hold);
        @(negedge clk);
        if0.s = s; if0.carry = cy; if0.load = 1'b1;
        @(negedge clk);
        if0.load = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        if0.s = 4'h0; if0.carry = 1'b0; if0.load = 1'b0;
        if1.s = 4'h0; if1.carry = 1'b0; if1.load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        load0(4'd8, 1'b0, 10);
        load0(4'd0, 1'b1, 10);
        load0(4'd8, 1'b1, 10);
        load0(4'hC, 1'b0, 10);
        load0(4'd3, 1'b0, 10);

        // Land the reset inside a tens phase with a competing capture.
        while (t0 % 8 != 6) @(negedge clk);
        if0.s = 4'd9; if0.carry = 1'b1; if0.load = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; if0.load = 1'b0;
        repeat (12) @(negedge clk);

        if0.load = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if0.s = 4'(i); if0.carry = i[0];
            @(negedge clk);
        end
        if0.load = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 20; i++)
            load0(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 9));

        repeat (4) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        @(negedge rst);
        repeat (3) @(negedge clk);
        if1.s = 4'd7; if1.carry = 1'b0; if1.load = 1'b1;
        @(negedge clk);
        if1.load = 1'b0;
        repeat (40) @(negedge clk);
        if1.s = 4'd5; if1.carry = 1'b1; if1.load = 1'b1;
        @(negedge clk);
        if1.load = 1'b0;
        repeat (20) @(negedge clk);
        if1.s = 4'hA; if1.carry = 1'b0; if1.load = 1'b1;
        @(negedge clk);
        if1.load = 1'b0;
    end

endmodule

`default_nettype wire
